// File: rtl/lut_eval_pkg.sv
// lut_eval_pkg: shared FSM encoding and truth-table sizing for the LUT evaluator.
package lut_eval_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_e;

   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/lut_eval_if.sv
// lut_eval_if: cfg / evaluate / sweep / result handshakes of the LUT evaluator.
interface lut_eval_if
   import lut_eval_pkg::*;
#(
   parameter int N_IN = 3
);

   localparam int TW = tt_width(N_IN);

   logic            cfg_valid;
   logic            cfg_ready;
   logic [TW-1:0]   cfg_data;
   logic            in_valid;
   logic            in_ready;
   logic [N_IN-1:0] in_vec;
   logic            sweep_start;
   logic            sweep_busy;
   logic            sweep_done;
   logic [N_IN:0]   sweep_ones;
   logic            out_valid;
   logic            out_ready;
   logic            out_bit;
   logic [N_IN-1:0] out_idx;

   modport slave (
      input  cfg_valid, cfg_data, in_valid, in_vec, sweep_start, out_ready,
      output cfg_ready, in_ready, sweep_busy, sweep_done, sweep_ones,
             out_valid, out_bit, out_idx
   );

   modport master (
      output cfg_valid, cfg_data, in_valid, in_vec, sweep_start, out_ready,
      input  cfg_ready, in_ready, sweep_busy, sweep_done, sweep_ones,
             out_valid, out_bit, out_idx
   );

endinterface

// File: rtl/lut_eval_core.sv
// lut_eval_core: combinational truth-table lookup, tt[vector].
module lut_eval_core
   import lut_eval_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  logic [tt_width(N_IN)-1:0] tt_i,
   input  logic [N_IN-1:0]           vec_i,
   output logic                      bit_o
);

   assign bit_o = tt_i[vec_i];

endmodule

// File: rtl/lut_eval_seq.sv
// lut_eval_seq: truth-table evaluator with single evaluations, table loads and
// a full input sweep that counts ones, all through one output register.
module lut_eval_seq
   import lut_eval_pkg::*;
#(
   parameter int                        N_IN    = 3,
   parameter logic [tt_width(N_IN)-1:0] TT_INIT = 8'h18
) (
   input logic       clk,
   input logic       rst_n,
   lut_eval_if.slave bus
);

   localparam int            TW      = tt_width(N_IN);
   localparam int            CW      = N_IN + 1;
   localparam logic [CW-1:0] LAST    = CW'(TW);
   localparam logic [0:0]    S_IDLE  = ST_IDLE;
   localparam logic [0:0]    S_SWEEP = ST_SWEEP;

   logic [0:0]      state_q, state_d;
   logic [TW-1:0]   tt_q, tt_d;
   logic            out_valid_q, out_valid_d;
   logic            out_bit_q, out_bit_d;
   logic [N_IN-1:0] out_idx_q, out_idx_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   ones_q, ones_d;
   logic [CW-1:0]   sweep_ones_q, sweep_ones_d;
   logic            sweep_done_q, sweep_done_d;

   logic            idle, can_load, out_fire;
   logic            sweep_go, cfg_rdy, cfg_go, in_rdy, eval_go;
   logic            sweep_step, last_fire, next_fire, load_out;
   logic [N_IN-1:0] sel_vec;
   logic            core_bit;

   assign idle     = state_q == S_IDLE;
   assign can_load = !out_valid_q || bus.out_ready;
   assign out_fire = out_valid_q && bus.out_ready;
   assign sweep_go = idle && bus.sweep_start && can_load;
   assign cfg_rdy  = idle && !out_valid_q && !bus.sweep_start;
   assign cfg_go   = bus.cfg_valid && cfg_rdy;
   assign in_rdy   = idle && can_load && !bus.sweep_start && !cfg_go;
   assign eval_go  = bus.in_valid && in_rdy;

   // idx_q holds the next vector to issue, so it equals LAST while the final
   // vector sits in the output register.
   assign sweep_step = !idle && out_fire;
   assign last_fire  = sweep_step && idx_q == LAST;
   assign next_fire  = sweep_step && !last_fire;
   assign load_out   = eval_go || sweep_go || next_fire;
   assign sel_vec    = idle ? (sweep_go ? '0 : bus.in_vec) : idx_q[N_IN-1:0];

   lut_eval_core #(.N_IN(N_IN)) u_core (
      .tt_i  (tt_q),
      .vec_i (sel_vec),
      .bit_o (core_bit)
   );

   always_comb begin
      state_d      = sweep_go ? S_SWEEP : last_fire ? S_IDLE : state_q;
      tt_d         = cfg_go ? bus.cfg_data : tt_q;
      out_valid_d  = load_out ? 1'b1 : out_fire ? 1'b0 : out_valid_q;
      out_bit_d    = load_out ? core_bit : out_bit_q;
      out_idx_d    = load_out ? sel_vec : out_idx_q;
      idx_d        = sweep_go ? CW'(1) : next_fire ? idx_q + CW'(1) : idx_q;
      ones_d       = sweep_go ? '0 : sweep_step ? ones_q + CW'(out_bit_q) : ones_q;
      sweep_ones_d = last_fire ? ones_q + CW'(out_bit_q) : sweep_ones_q;
      sweep_done_d = last_fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tt_q         <= TT_INIT;
         out_valid_q  <= 1'b0;
         out_bit_q    <= 1'b0;
         out_idx_q    <= '0;
         idx_q        <= '0;
         ones_q       <= '0;
         sweep_ones_q <= '0;
         sweep_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tt_q         <= tt_d;
         out_valid_q  <= out_valid_d;
         out_bit_q    <= out_bit_d;
         out_idx_q    <= out_idx_d;
         idx_q        <= idx_d;
         ones_q       <= ones_d;
         sweep_ones_q <= sweep_ones_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign bus.cfg_ready  = cfg_rdy;
   assign bus.in_ready   = in_rdy;
   assign bus.sweep_busy = state_q == S_SWEEP;
   assign bus.sweep_done = sweep_done_q;
   assign bus.sweep_ones = sweep_ones_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_bit    = out_bit_q;
   assign bus.out_idx    = out_idx_q;

endmodule

// File: tb/tb_lut_eval_seq.sv
// tb_lut_eval_seq: directed and randomized checks of lut_eval_seq against a
// handshake-level reference model.
module tb_lut_eval_seq;

   localparam int N  = 3;
   localparam int TW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int fails = 0;

   logic [TW-1:0] tt_m;
   logic          ov_m, ob_m;
   logic [N-1:0]  oi_m;

   lut_eval_if #(.N_IN(N)) bus ();

   lut_eval_seq #(.N_IN(N), .TT_INIT(8'h18)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      bus.cfg_valid   = 1'b0;
      bus.in_valid    = 1'b0;
      bus.sweep_start = 1'b0;
   endtask

   task automatic load_tt(input logic [TW-1:0] d);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = d;
      #1;
      chk("cfg_ready", bus.cfg_ready, 1);
      tick();
      bus.cfg_valid = 1'b0;
      tt_m = d;
   endtask

   // Full sweep with every competing request raised in the start cycle and an
   // optional 5-cycle downstream stall while vector stall_at is presented.
   task automatic run_sweep(input int stall_at);
      int ones;
      ones = 0;
      bus.out_ready   = 1'b1;
      bus.sweep_start = 1'b1;
      bus.cfg_valid   = 1'b1;
      bus.cfg_data    = ~tt_m;
      bus.in_valid    = 1'b1;
      bus.in_vec      = N'($urandom);
      #1;
      chk("start_cfg_ready", bus.cfg_ready, 0);
      chk("start_in_ready", bus.in_ready, 0);
      tick();
      idle_inputs();
      for (int k = 0; k < TW; k++) begin
         chk("sw_busy", bus.sweep_busy, 1);
         chk("sw_valid", bus.out_valid, 1);
         chk("sw_idx", bus.out_idx, k);
         chk("sw_bit", bus.out_bit, tt_m[k]);
         chk("sw_done_early", bus.sweep_done, 0);
         if (k == stall_at) begin
            chk("sw_in_ready", bus.in_ready, 0);
            chk("sw_cfg_ready", bus.cfg_ready, 0);
            bus.out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               chk("stall_valid", bus.out_valid, 1);
               chk("stall_idx", bus.out_idx, k);
               chk("stall_bit", bus.out_bit, tt_m[k]);
            end
            bus.out_ready = 1'b1;
         end
         ones += int'(tt_m[k]);
         tick();
      end
      chk("sw_done", bus.sweep_done, 1);
      chk("sw_ones", bus.sweep_ones, ones);
      chk("sw_busy_end", bus.sweep_busy, 0);
      chk("sw_valid_end", bus.out_valid, 0);
      tick();
      chk("sw_done_pulse", bus.sweep_done, 0);
      chk("sw_ones_hold", bus.sweep_ones, ones);
   endtask

   initial begin
      idle_inputs();
      bus.cfg_data  = '0;
      bus.in_vec    = '0;
      bus.out_ready = 1'b0;
      tt_m = 8'h18;
      tick();
      tick();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_bit", bus.out_bit, 0);
      chk("rst_idx", bus.out_idx, 0);
      chk("rst_ones", bus.sweep_ones, 0);
      chk("rst_done", bus.sweep_done, 0);
      chk("rst_busy", bus.sweep_busy, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_cfg_ready", bus.cfg_ready, 1);

      // directed evaluations back to back
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_vec    = 3'b011;
      tick();
      chk("ev3_valid", bus.out_valid, 1);
      chk("ev3_bit", bus.out_bit, 1);
      chk("ev3_idx", bus.out_idx, 3);
      bus.in_vec = 3'b100;
      tick();
      chk("ev4_bit", bus.out_bit, 1);
      chk("ev4_idx", bus.out_idx, 4);
      bus.in_vec = 3'b000;
      tick();
      chk("ev0_bit", bus.out_bit, 0);
      chk("ev0_idx", bus.out_idx, 0);
      bus.in_valid = 1'b0;
      tick();
      chk("ev_drain", bus.out_valid, 0);

      run_sweep(3);
      load_tt(8'hFF);
      run_sweep(-1);
      load_tt(8'h00);
      run_sweep(6);

      // randomized traffic against the handshake model
      ov_m = 1'b0;
      ob_m = 1'b0;
      oi_m = 3'd7;
      for (int c = 0; c < 300; c++) begin
         logic exp_cr, exp_ir;
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_vec    = N'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.cfg_valid = ($urandom_range(0, 7) == 0);
         bus.cfg_data  = TW'($urandom);
         #1;
         exp_cr = !ov_m;
         exp_ir = (!ov_m || bus.out_ready) && !(bus.cfg_valid && exp_cr);
         chk("rnd_cfg_ready", bus.cfg_ready, exp_cr);
         chk("rnd_in_ready", bus.in_ready, exp_ir);
         if (bus.cfg_valid && exp_cr) tt_m = bus.cfg_data;
         if (bus.in_valid && exp_ir) begin
            ov_m = 1'b1;
            ob_m = tt_m[bus.in_vec];
            oi_m = bus.in_vec;
         end else if (bus.out_ready) begin
            ov_m = 1'b0;
         end
         tick();
         chk("rnd_valid", bus.out_valid, ov_m);
         chk("rnd_bit", bus.out_bit, ob_m);
         chk("rnd_idx", bus.out_idx, oi_m);
      end
      idle_inputs();
      bus.out_ready = 1'b1;
      tick();
      run_sweep(0);

      // sweep_start ignored while a result is stalled
      bus.in_valid = 1'b1;
      bus.in_vec   = 3'd1;
      tick();
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b0;
      bus.sweep_start = 1'b1;
      tick();
      bus.sweep_start = 1'b0;
      chk("ign_busy", bus.sweep_busy, 0);
      chk("ign_valid", bus.out_valid, 1);
      chk("ign_idx", bus.out_idx, 1);
      bus.out_ready = 1'b1;
      tick();
      chk("ign_drain", bus.out_valid, 0);

      // reset aborts a sweep at index 4
      load_tt(8'hFF);
      run_sweep(-1);
      bus.sweep_start = 1'b1;
      tick();
      bus.sweep_start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("ab_idx", bus.out_idx, 4);
      chk("ab_busy_pre", bus.sweep_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("ab_busy", bus.sweep_busy, 0);
      chk("ab_valid", bus.out_valid, 0);
      chk("ab_ones", bus.sweep_ones, 0);
      chk("ab_done", bus.sweep_done, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ab_done_after", bus.sweep_done, 0);
      chk("ab_ones_after", bus.sweep_ones, 0);
      tt_m = 8'h18;
      run_sweep(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/lut_eval_seq.md
LUT_EVAL_SEQ -- requirements
Module: lut_eval_seq

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- N_IN, 3, number of logic inputs (1..8)
- TT_INIT, 8'h18, truth-table reset value, width 2**N_IN
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  truth-table load request
- cfg_ready  out  1  load accepted when high with cfg_valid
- cfg_data  in  2**N_IN  new truth table; bit i = output for input vector i
- in_valid  in  1  evaluation request
- in_ready  out  1  evaluation accepted
- in_vec  in  N_IN  input vector; bit 0 = first input
- sweep_start  in  1  one-cycle pulse, enumerate all input vectors
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse after the last sweep output handshake
- sweep_ones  out  N_IN+1  count of 1 outputs from the last completed sweep
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_bit  out  1  evaluated function value
- out_idx  out  N_IN  input vector producing out_bit

Function
REQ-003 The block SHALL hold a truth-table register tt of width 2**N_IN; out_bit SHALL equal tt[vector] for the vector captured.
REQ-004 The FSM SHALL have states IDLE and SWEEP; IDLE serves cfg and evaluation; SWEEP enumerates vectors.
REQ-005 Evaluation latency SHALL be 1 cycle: in_valid&&in_ready at edge t yields out_valid=1 with the result from edge t onward.
REQ-006 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready); back-to-back evaluation SHALL sustain one result per cycle while out_ready=1.
REQ-007 out_valid, out_bit and out_idx SHALL hold stable while out_valid && !out_ready.
REQ-008 cfg_ready SHALL be (state==IDLE) && !out_valid; an accepted load SHALL update tt at that edge, and evaluations accepted in later cycles SHALL use the new table.
REQ-009 In IDLE, priority on the same cycle SHALL be sweep_start > cfg_valid > in_valid; a losing request SHALL see its ready low.
REQ-010 sweep_start in IDLE SHALL enter SWEEP only when !out_valid || out_ready; otherwise it SHALL be ignored; sweep_start in SWEEP SHALL be ignored.
REQ-011 In SWEEP, an index counter SHALL issue vectors 0..2**N_IN-1 in ascending order, one per output handshake, through the same output register (REQ-005 to REQ-007).
REQ-012 A running ones counter SHALL add out_bit on each sweep output handshake; after the handshake of index 2**N_IN-1, sweep_ones SHALL load the total, sweep_done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
REQ-013 The index SHALL not wrap inside a sweep; N_IN=8 SHALL count 256 vectors using a counter of width N_IN+1.
REQ-014 sweep_busy SHALL be 1 exactly while state==SWEEP; in_ready and cfg_ready SHALL be 0 in SWEEP.

Reset
REQ-015 rst_n low SHALL asynchronously force: state=IDLE, tt=TT_INIT, out_valid=0, out_bit=0, out_idx=0, sweep_ones=0, sweep_done=0, and index and ones counters=0.
REQ-016 Reset mid-sweep SHALL abort the sweep without a sweep_done pulse; sweep_ones SHALL read 0.

Structure
REQ-017 Package lut_eval_pkg SHALL hold the FSM state enum and the function tt_width(n)=2**n.
REQ-018 One sub-module, lut_eval_core, SHALL hold the combinational tt[vector] select; all state SHALL reside in lut_eval_seq.

Verification
REQ-019 Reset defaults, in_vec=3'b011 then 3'b100 with out_ready=1 -> out_bit=1, 1 on consecutive cycles; in_vec=3'b000 -> 0.
REQ-020 sweep_start with TT_INIT -> out_idx 0..7, out_bit 0,0,0,1,1,0,0,0; sweep_ones=2; one sweep_done pulse.
REQ-021 Load cfg_data=8'hFF, then sweep -> sweep_ones=8; load 8'h00, then sweep -> sweep_ones=0.
REQ-022 out_ready held 0 for 5 cycles mid-sweep -> output stable, no index skipped, final sweep_ones unchanged.
REQ-023 sweep_start, cfg_valid and in_valid in the same cycle -> only the sweep starts; cfg_ready=0 and in_ready=0 that cycle.
REQ-024 rst_n low at sweep index 4 -> IDLE, tt=8'h18, no sweep_done, sweep_ones=0.
